uart_tx_arbiter: RTL and testbench

Packet-atomic arbiter that shares the single UART TX byte stream between two packet sources. Typical sources are the framed image stream (port 0) and a command/telemetry response stream (port 1). A grant is held for a whole packet, so framed packets are never interleaved. An idle timeout recovers the link when a source stalls mid-packet. The block sits between the packet sources and the UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic two-source arbiter in front of the UART TX byte stream.
// A grant is held until the owning source fires its last byte, or until the source
// goes quiet for TimeoutCycles cycles, in which case the link is forcibly released.
module uart_tx_arbiter #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s0_valid_i,
  output logic                 s0_ready_o,
  input  logic [DataWidth-1:0] s0_data_i,
  input  logic                 s0_last_i,
  input  logic                 s1_valid_i,
  output logic                 s1_ready_o,
  input  logic [DataWidth-1:0] s1_data_i,
  input  logic                 s1_last_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  localparam int unsigned TimerWidth = $clog2(TimeoutCycles);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  pick;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DataWidth-1:0]  sel_data;

  // Route the currently owning source onto a common set of wires.
  always_comb begin
    sel_valid = s0_valid_i;
    sel_last  = s0_last_i;
    sel_data  = s0_data_i;
    if (state_q == StBusy1) begin
      sel_valid = s1_valid_i;
      sel_last  = s1_last_i;
      sel_data  = s1_data_i;
    end
  end

  // Arbitration, packet hold, idle timer and the combinational pass-through.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    timer_d    = timer_q;
    pick       = 1'b0;
    valid_o    = 1'b0;
    data_o     = '0;
    last_o     = 1'b0;
    s0_ready_o = 1'b0;
    s1_ready_o = 1'b0;
    grant_o    = 2'b00;
    timeout_o  = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (s0_valid_i || s1_valid_i) begin
          // On a tie the port that did not own the link last time wins.
          pick    = (s0_valid_i && s1_valid_i) ? ~last_q : s1_valid_i;
          last_d  = pick;
          state_d = pick ? StBusy1 : StBusy0;
        end
      end
      StBusy0, StBusy1: begin
        valid_o = sel_valid;
        data_o  = sel_data;
        last_o  = sel_last;
        if (state_q == StBusy1) begin
          s1_ready_o = ready_i;
          grant_o    = 2'b10;
        end else begin
          s0_ready_o = ready_i;
          grant_o    = 2'b01;
        end
        if (sel_valid) begin
          // A source stalled only by UART backpressure is not idle.
          timer_d = '0;
          if (ready_i && sel_last) begin
            state_d = StIdle;
          end
        end else if (timer_q == TimerLast) begin
          // Keep last_q so the other port has priority after a stalled packet.
          timer_d   = '0;
          state_d   = StIdle;
          timeout_o = 1'b1;
        end else begin
          timer_d = timer_q + TimerWidth'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, priority pointer and idle timer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the two-source UART TX arbiter.
// Sources are queue-driven; every byte loaded is also pushed, in expected grant
// order, to a scoreboard that is popped whenever the UART side accepts a byte.
module tb_uart_tx_arbiter;

  localparam int TC = 8;

  logic       clk;
  logic       rst_ni;
  logic       s0_valid_i, s0_ready_o, s0_last_i;
  logic [7:0] s0_data_i;
  logic       s1_valid_i, s1_ready_o, s1_last_i;
  logic [7:0] s1_data_i;
  logic       valid_o, ready_i, last_o, timeout_o;
  logic [7:0] data_o;
  logic [1:0] grant_o;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [10:0] expQ[$];

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   timeoutCount = 0;
  int   lastTimeoutCycle = 0;
  int   s1Leak = 0;
  logic fire0 = 1'b0;
  logic fire1 = 1'b0;

  uart_tx_arbiter #(
    .DataWidth    (8),
    .TimeoutCycles(TC)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .s0_valid_i(s0_valid_i),
    .s0_ready_o(s0_ready_o),
    .s0_data_i (s0_data_i),
    .s0_last_i (s0_last_i),
    .s1_valid_i(s1_valid_i),
    .s1_ready_o(s1_ready_o),
    .s1_data_i (s1_data_i),
    .s1_last_i (s1_last_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .last_o    (last_o),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time the timeout pulse.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Safety net in case the DUT never completes a handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete (errors so far %0d)", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load one byte into a source queue and record it in the scoreboard.
  task automatic applyStimulus(input int port, input logic [7:0] data, input logic last);
    if (port == 0) begin
      q0.push_back({last, data});
      expQ.push_back({2'b01, last, data});
    end else begin
      q1.push_back({last, data});
      expQ.push_back({2'b10, last, data});
    end
  endtask

  // Wait for grant g, then count how many consecutive cycles it is held.
  task automatic measureGrant(input string tag, input logic [1:0] g,
                              output int waitN, output int len, output int startCycle);
    waitN = 0;
    len = 0;
    startCycle = 0;
    while (grant_o !== g && waitN < 5000) begin
      @(negedge clk);
      waitN++;
    end
    if (grant_o !== g) begin
      checkOutput({tag, "_grant_seen"}, 32'(grant_o), 32'(g));
      return;
    end
    startCycle = cycle;
    while (grant_o === g && len < 5000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic waitDrain(input string tag);
    int b;
    b = 0;
    while (expQ.size() > 0 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Port 0 source: present queue head, pop it after an accepted handshake.
  initial begin
    s0_valid_i = 1'b0;
    s0_data_i  = 8'h00;
    s0_last_i  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (fire0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        s0_valid_i = 1'b1;
        {s0_last_i, s0_data_i} = q0[0];
      end else begin
        s0_valid_i = 1'b0;
        s0_last_i  = 1'b0;
        s0_data_i  = 8'h00;
      end
    end
  end

  // Port 1 source: same behaviour as port 0.
  initial begin
    s1_valid_i = 1'b0;
    s1_data_i  = 8'h00;
    s1_last_i  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (fire1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        s1_valid_i = 1'b1;
        {s1_last_i, s1_data_i} = q1[0];
      end else begin
        s1_valid_i = 1'b0;
        s1_last_i  = 1'b0;
        s1_data_i  = 8'h00;
      end
    end
  end

  // Output monitor: scoreboard compare on every UART handshake, plus event counters.
  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(negedge clk);
      fire0 = s0_valid_i && s0_ready_o;
      fire1 = s1_valid_i && s1_ready_o;
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_underflow", 32'(expQ.size()), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("byte", 32'({grant_o, last_o, data_o}), 32'(e));
        end
      end
      if (timeout_o) begin
        timeoutCount++;
        lastTimeoutCycle = cycle;
      end
      if (grant_o == 2'b01 && s1_ready_o) s1Leak++;
    end
  end

  // Directed scenarios.
  initial begin
    int w, l, s, toBase;
    logic [7:0] t1 [4];
    t1 = '{8'h99, 8'h11, 8'hA5, 8'h5A};
    rst_ni  = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({valid_o, s0_ready_o, s1_ready_o, data_o, last_o, grant_o, timeout_o}), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("idle_grant", 32'(grant_o), 32'd0);

    $display("[TB] single source packet");
    for (int i = 0; i < 4; i++) applyStimulus(0, t1[i], i == 3);
    measureGrant("t1", 2'b01, w, l, s);
    checkOutput("t1_arb_latency", 32'(w), 32'd2);
    checkOutput("t1_grant_len", 32'(l), 32'd4);
    checkOutput("t1_bubble", 32'(grant_o), 32'd0);
    waitDrain("t1_drain");

    $display("[TB] contest after reset");
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'(8'h10 + i), i == 2);
    for (int i = 0; i < 2; i++) applyStimulus(1, 8'(8'h20 + i), i == 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 8'(8'h30 + i), i == 1);
    measureGrant("t2a", 2'b01, w, l, s);
    checkOutput("t2a_wait", 32'(w), 32'd2);
    checkOutput("t2a_len", 32'(l), 32'd3);
    checkOutput("t2a_bubble", 32'(grant_o), 32'd0);
    measureGrant("t2b", 2'b10, w, l, s);
    checkOutput("t2b_wait", 32'(w), 32'd1);
    checkOutput("t2b_len", 32'(l), 32'd2);
    measureGrant("t2c", 2'b01, w, l, s);
    checkOutput("t2c_wait", 32'(w), 32'd1);
    checkOutput("t2c_len", 32'(l), 32'd2);
    waitDrain("t2_drain");

    $display("[TB] no interleave during long packet");
    for (int i = 0; i < 1026; i++) applyStimulus(0, 8'(i) ^ 8'h5C, i == 1025);
    fork
      measureGrant("t3a", 2'b01, w, l, s);
      begin
        repeat (500) @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'hC0 + i), i == 2);
      end
    join
    checkOutput("t3a_len", 32'(l), 32'd1026);
    checkOutput("t3_no_s1_ready", 32'(s1Leak), 32'd0);
    checkOutput("t3_bubble", 32'(grant_o), 32'd0);
    measureGrant("t3b", 2'b10, w, l, s);
    checkOutput("t3b_wait", 32'(w), 32'd1);
    checkOutput("t3b_len", 32'(l), 32'd3);
    waitDrain("t3_drain");

    $display("[TB] backpressure without timeout");
    toBase = timeoutCount;
    for (int i = 0; i < 6; i++) applyStimulus(0, 8'(8'h40 + i), i == 5);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      ready_i = (i < 6) ? ((i % 2) == 0) : (i >= 18);
      if (i == 16) begin
        @(negedge clk);
        checkOutput("t4_grant_held", 32'(grant_o), 32'd1);
      end
    end
    ready_i = 1'b1;
    @(negedge clk);
    waitDrain("t4_drain");
    checkOutput("t4_no_timeout", 32'(timeoutCount - toBase), 32'd0);

    $display("[TB] stalled source timeout");
    toBase = timeoutCount;
    applyStimulus(0, 8'hE1, 1'b0);
    applyStimulus(0, 8'hE2, 1'b0);
    fork
      measureGrant("t5a", 2'b01, w, l, s);
      begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'hB0 + i), i == 2);
      end
    join
    checkOutput("t5a_len", 32'(l), 32'(2 + TC));
    checkOutput("t5_timeout_pulses", 32'(timeoutCount - toBase), 32'd1);
    checkOutput("t5_timeout_cycle", 32'(lastTimeoutCycle - s), 32'(2 + TC - 1));
    checkOutput("t5_bubble", 32'(grant_o), 32'd0);
    measureGrant("t5b", 2'b10, w, l, s);
    checkOutput("t5b_wait", 32'(w), 32'd1);
    checkOutput("t5b_len", 32'(l), 32'd3);
    waitDrain("t5_drain");

    $display("[TB] async reset during port 1 packet");
    for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'h70 + i), i == 9);
    w = 0;
    while (grant_o !== 2'b10 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("t6_busy1", 32'(grant_o), 32'd2);
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("t6_async_outputs",
                32'({valid_o, s0_ready_o, s1_ready_o, data_o, last_o, grant_o, timeout_o}), 32'd0);
    q1.delete();
    expQ.delete();
    @(negedge clk);
    checkOutput("t6_reset_hold",
                32'({valid_o, s0_ready_o, s1_ready_o, data_o, last_o, grant_o, timeout_o}), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) applyStimulus(0, 8'(8'h80 + i), i == 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 8'(8'h90 + i), i == 1);
    measureGrant("t6a", 2'b01, w, l, s);
    checkOutput("t6a_wait", 32'(w), 32'd2);
    checkOutput("t6a_len", 32'(l), 32'd2);
    measureGrant("t6b", 2'b10, w, l, s);
    checkOutput("t6b_wait", 32'(w), 32'd1);
    checkOutput("t6b_len", 32'(l), 32'd2);
    waitDrain("t6_drain");

    checkOutput("s1_ready_leak", 32'(s1Leak), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
